// File: rtl/ptp_rx_parser_if.sv
// Bus bundle for the PTP receive parser: AXI-Stream byte input plus Wishbone register slave.
// A byte moves only in a cycle with tvalid & tready; a Wishbone request is held with stb until the one-cycle ack.
interface ptp_rx_parser_if;
  logic [7:0]  axis_tdata_i;
  logic        axis_tvalid_i;
  logic        axis_tready_o;
  logic        axis_tlast_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_data_o;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;

  modport slave (
    input  axis_tdata_i, axis_tvalid_i, axis_tlast_i,
    input  wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
    output axis_tready_o, wbs_data_o, wbs_ack_o
  );

  modport master (
    output axis_tdata_i, axis_tvalid_i, axis_tlast_i,
    output wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
    input  axis_tready_o, wbs_data_o, wbs_ack_o
  );
endinterface

// File: rtl/ptp_rx_parser.sv
// PTP receive header parser: extracts header/timestamp fields from an Ethernet byte stream
// and exposes them, plus status and counters, through Wishbone registers.
module ptp_rx_parser #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0200,
  parameter logic [15:0] ETHERTYPE = 16'h88F7
) (
  input  logic           clk,
  input  logic           rst,
  ptp_rx_parser_if.slave bus,
  output logic [1:0]     state_dbg_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PARSE = 2'd1, S_DROP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        tready_q, commit_q, commit_d, runt_q, runt_d;
  logic        beat, etype_bad;

  logic [7:0]  sh_eth_hi_q, sh_tm_q, sh_dom_q;
  logic [3:0]  sh_ver_q;
  logic [15:0] sh_len_q, sh_seq_q;
  logic [47:0] sh_sec_q;
  logic [31:0] sh_ns_q;

  logic        ctrl_en_q;
  logic [2:0]  status_q, status_d;
  logic [31:0] hdr_q, id_q, seclo_q, nsec_q, rx_cnt_q, err_cnt_q;
  logic [15:0] sechi_q;

  logic        ack_q, ack_d, done_q, wr_en, wb_hit;
  logic [7:0]  wb_off;
  logic [31:0] rdata_q, rdata_d;
  logic        unused_wdata;

  assign beat             = bus.axis_tvalid_i & tready_q;
  assign etype_bad        = (idx_q == 6'd13) && ({sh_eth_hi_q, bus.axis_tdata_i} != ETHERTYPE);
  assign bus.axis_tready_o = tready_q;
  assign state_dbg_o      = state_q;
  assign unused_wdata     = ^bus.wbs_data_i[31:1];

  // Byte 0 always arrives in IDLE, so enable is sampled only there.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    commit_d = 1'b0;
    runt_d   = 1'b0;
    if (beat) begin
      idx_d = bus.axis_tlast_i ? 6'd0 : ((idx_q == 6'd63) ? idx_q : idx_q + 6'd1);
      unique case (state_q)
        S_IDLE: begin
          if (bus.axis_tlast_i) runt_d = ctrl_en_q;
          else                  state_d = ctrl_en_q ? S_PARSE : S_DROP;
        end
        S_PARSE: begin
          if (bus.axis_tlast_i) begin
            state_d = S_IDLE;
            if (idx_q >= 6'd57)   commit_d = 1'b1;
            else if (!etype_bad)  runt_d   = 1'b1;
          end else if (etype_bad) begin
            state_d = S_DROP;
          end
        end
        S_DROP:  if (bus.axis_tlast_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 6'd0;
      tready_q <= 1'b0;
      commit_q <= 1'b0;
      runt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tready_q <= 1'b1;
      commit_q <= commit_d;
      runt_q   <= runt_d;
    end
  end

  // Multi-byte fields arrive MSB first, so they shift in from the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_eth_hi_q <= '0;
      sh_tm_q     <= '0;
      sh_ver_q    <= '0;
      sh_len_q    <= '0;
      sh_dom_q    <= '0;
      sh_seq_q    <= '0;
      sh_sec_q    <= '0;
      sh_ns_q     <= '0;
    end else if (beat && state_q == S_PARSE) begin
      case (idx_q)
        6'd12:                                    sh_eth_hi_q <= bus.axis_tdata_i;
        6'd14:                                    sh_tm_q     <= bus.axis_tdata_i;
        6'd15:                                    sh_ver_q    <= bus.axis_tdata_i[3:0];
        6'd16, 6'd17:                             sh_len_q    <= {sh_len_q[7:0], bus.axis_tdata_i};
        6'd18:                                    sh_dom_q    <= bus.axis_tdata_i;
        6'd44, 6'd45:                             sh_seq_q    <= {sh_seq_q[7:0], bus.axis_tdata_i};
        6'd48, 6'd49, 6'd50, 6'd51, 6'd52, 6'd53: sh_sec_q    <= {sh_sec_q[39:0], bus.axis_tdata_i};
        6'd54, 6'd55, 6'd56, 6'd57:               sh_ns_q     <= {sh_ns_q[23:0], bus.axis_tdata_i};
        default: ;
      endcase
    end
  end

  assign wb_hit = (bus.wbs_addr_i[31:8] == BASE_ADDR[31:8]);
  assign wb_off = bus.wbs_addr_i[7:0];
  assign ack_d  = bus.wbs_stb_i && !ack_q && !done_q;
  assign wr_en  = ack_q && bus.wbs_we_i && wb_hit;

  // Hardware set is applied after the W1C so it wins in the same cycle.
  always_comb begin
    status_d = status_q;
    if (wr_en && wb_off == 8'h04) status_d = status_q & ~bus.wbs_data_i[2:0];
    if (commit_q) begin
      status_d[0] = 1'b1;
      if (status_q[0]) status_d[2] = 1'b1;
    end
    if (runt_q) status_d[1] = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    if (ack_d && wb_hit) begin
      case (wb_off)
        8'h00:   rdata_d = {31'd0, ctrl_en_q};
        8'h04:   rdata_d = {29'd0, status_q};
        8'h08:   rdata_d = hdr_q;
        8'h0C:   rdata_d = id_q;
        8'h10:   rdata_d = {16'd0, sechi_q};
        8'h14:   rdata_d = seclo_q;
        8'h18:   rdata_d = nsec_q;
        8'h1C:   rdata_d = rx_cnt_q;
        8'h20:   rdata_d = err_cnt_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en_q <= 1'b0;
      status_q  <= '0;
      hdr_q     <= '0;
      id_q      <= '0;
      sechi_q   <= '0;
      seclo_q   <= '0;
      nsec_q    <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      status_q <= status_d;
      ack_q    <= ack_d;
      // done_q blocks a second ack until stb has dropped for a cycle.
      done_q   <= bus.wbs_stb_i && (done_q || ack_q);
      rdata_q  <= rdata_d;
      if (wr_en && wb_off == 8'h00) ctrl_en_q <= bus.wbs_data_i[0];
      if (commit_q) begin
        hdr_q    <= {sh_tm_q, 4'h0, sh_ver_q, sh_len_q};
        id_q     <= {8'h00, sh_dom_q, sh_seq_q};
        sechi_q  <= sh_sec_q[47:32];
        seclo_q  <= sh_sec_q[31:0];
        nsec_q   <= sh_ns_q;
        rx_cnt_q <= rx_cnt_q + 32'd1;
      end
      if (runt_q) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign bus.wbs_ack_o  = ack_q;
  assign bus.wbs_data_o = rdata_q;
endmodule

// File: tb/tb_ptp_rx_parser.sv
// Self-checking bench for ptp_rx_parser: directed scenarios plus randomized frames
// compared against a frame-level register model.
module tb_ptp_rx_parser;
  localparam logic [31:0] BASE  = 32'h0300_0200;
  localparam logic [15:0] ETYPE = 16'h88F7;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  ptp_rx_parser_if bus_if();

  ptp_rx_parser #(.BASE_ADDR(BASE), .ETHERTYPE(ETYPE)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  frm[$];

  logic        m_en;
  logic [2:0]  m_status;
  logic [31:0] m_hdr, m_id, m_sechi, m_seclo, m_nsec, m_rx, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_status = '0; m_hdr = '0; m_id = '0;
    m_sechi = '0; m_seclo = '0; m_nsec = '0; m_rx = '0; m_err = '0;
  endtask

  // Whole-frame outcome from the frame bytes and the enable seen at its start.
  task automatic model_frame(input logic en);
    int n;
    logic [7:0] v;
    n = frm.size();
    if (!en) return;
    if (n >= 14 && {frm[12], frm[13]} != ETYPE) return;
    if (n < 58) begin
      m_status[1] = 1'b1;
      m_err = m_err + 32'd1;
      return;
    end
    if (m_status[0]) m_status[2] = 1'b1;
    m_status[0] = 1'b1;
    m_rx = m_rx + 32'd1;
    v = frm[15];
    m_hdr   = {frm[14], 4'h0, v[3:0], frm[16], frm[17]};
    m_id    = {8'h00, frm[18], frm[44], frm[45]};
    m_sechi = {16'h0000, frm[48], frm[49]};
    m_seclo = {frm[50], frm[51], frm[52], frm[53]};
    m_nsec  = {frm[54], frm[55], frm[56], frm[57]};
  endtask

  // ---------------- drivers ----------------
  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    logic got;
    bus_if.wbs_addr_i = addr;
    bus_if.wbs_we_i   = we;
    bus_if.wbs_data_i = wdata;
    bus_if.wbs_stb_i  = 1'b1;
    got   = 1'b0;
    rdata = '0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(posedge clk); #1;
      if (bus_if.wbs_ack_o) begin
        got   = 1'b1;
        rdata = bus_if.wbs_data_o;
      end
    end
    if (!got) check("wb_ack_timeout", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(addr, 1'b1, data, dummy);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    wb_xfer(addr, 1'b0, 32'd0, data);
  endtask

  task automatic build_frame(input int len, input logic [15:0] et, input logic [7:0] b14,
                             input logic [3:0] ver, input logic [15:0] mlen, input logic [7:0] dom,
                             input logic [15:0] seq, input logic [47:0] sec, input logic [31:0] ns);
    logic [7:0] b [0:127];
    for (int i = 0; i < 128; i++) b[i] = 8'($urandom);
    b[12] = et[15:8];   b[13] = et[7:0];
    b[14] = b14;        b[15] = {4'($urandom), ver};
    b[16] = mlen[15:8]; b[17] = mlen[7:0];
    b[18] = dom;
    b[44] = seq[15:8];  b[45] = seq[7:0];
    for (int k = 0; k < 6; k++) b[48+k] = sec[47-8*k -: 8];
    for (int k = 0; k < 4; k++) b[54+k] = ns[31-8*k -: 8];
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(b[i]);
  endtask

  task automatic random_frame();
    int len;
    logic [15:0] et;
    case ($urandom_range(0, 5))
      0:       len = $urandom_range(1, 14);
      1:       len = $urandom_range(15, 57);
      default: len = $urandom_range(58, 90);
    endcase
    et = ($urandom_range(0, 4) == 0) ? 16'h0800 : ETYPE;
    build_frame(len, et, 8'($urandom), 4'($urandom), 16'($urandom), 8'($urandom),
                16'($urandom), 48'({$urandom, $urandom}), $urandom);
  endtask

  task automatic send_frame(input logic gaps);
    logic rdy_ok;
    rdy_ok = 1'b1;
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        bus_if.axis_tvalid_i = 1'b0;
        bus_if.axis_tlast_i  = 1'b0;
        @(posedge clk); #1;
      end
      bus_if.axis_tdata_i  = frm[i];
      bus_if.axis_tvalid_i = 1'b1;
      bus_if.axis_tlast_i  = (i == frm.size() - 1);
      @(negedge clk);
      if (bus_if.axis_tready_o !== 1'b1) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.axis_tvalid_i = 1'b0;
    bus_if.axis_tlast_i  = 1'b0;
    check("tready_during_frame", {31'd0, rdy_ok}, 32'd1);
  endtask

  task automatic run_frame(input logic gaps);
    send_frame(gaps);
    model_frame(m_en);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] r;
    exp_q.push_back({31'd0, m_en});
    exp_q.push_back({29'd0, m_status});
    exp_q.push_back(m_hdr);
    exp_q.push_back(m_id);
    exp_q.push_back(m_sechi);
    exp_q.push_back(m_seclo);
    exp_q.push_back(m_nsec);
    exp_q.push_back(m_rx);
    exp_q.push_back(m_err);
    for (int k = 0; k < 9; k++) begin
      wb_read(BASE + 32'(4 * k), r);
      check($sformatf("%s_reg%02h", tag, 4 * k), r, exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int acks;
    logic [31:0] w;

    rst = 1'b1;
    bus_if.axis_tdata_i = '0; bus_if.axis_tvalid_i = 1'b0; bus_if.axis_tlast_i = 1'b0;
    bus_if.wbs_addr_i = '0; bus_if.wbs_data_i = '0; bus_if.wbs_we_i = 1'b0; bus_if.wbs_stb_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("tready_in_reset", {31'd0, bus_if.axis_tready_o}, 32'd0);
    check("ack_in_reset", {31'd0, bus_if.wbs_ack_o}, 32'd0);
    check("rdata_in_reset", bus_if.wbs_data_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_reset", {31'd0, bus_if.axis_tready_o}, 32'd1);
    check_regs("reset");

    // Wishbone: stb held three cycles gives one ack; unmapped accesses read 0
    bus_if.wbs_addr_i = BASE; bus_if.wbs_we_i = 1'b0; bus_if.wbs_stb_i = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus_if.wbs_ack_o) acks++;
      if (c == 2) bus_if.wbs_stb_i = 1'b0;
    end
    check("stb_held_single_ack", 32'(acks), 32'd1);
    wb_read(BASE + 32'h40, r);
    check("unmapped_off_40", r, 32'd0);
    wb_write(BASE + 32'h100, 32'd1);
    wb_read(BASE + 32'h100, r);
    check("other_page_read", r, 32'd0);
    wb_read(BASE, r);
    check("other_page_write_ignored", r, 32'd0);

    // Sync frame
    wb_write(BASE, 32'd1); m_en = 1'b1;
    build_frame(58, ETYPE, 8'h10, 4'd2, 16'h002C, 8'h00, 16'h1234, 48'h0000_0000_0016, 32'h0000_AAAA);
    run_frame(1'b0);
    check_regs("sync");
    wb_read(BASE + 32'h08, r);
    check("sync_hdr", r, 32'h1002_002C);
    wb_read(BASE + 32'h0C, r);
    check("sync_id", r, 32'h0000_1234);

    // Runt of 40 bytes, then W1C of err
    build_frame(40, ETYPE, 8'h11, 4'd2, 16'h0040, 8'h05, 16'h7777, 48'h1, 32'h2);
    run_frame(1'b1);
    check_regs("runt");
    wb_write(BASE + 32'h04, 32'd2); m_status[1] = 1'b0;
    check_regs("runt_w1c");

    // Wrong EtherType followed by a good frame
    wb_write(BASE + 32'h04, 32'd7); m_status = '0;
    build_frame(60, 16'h0800, 8'h00, 4'd2, 16'h002C, 8'h00, 16'h4444, 48'h9, 32'h9);
    run_frame(1'b1);
    build_frame(64, ETYPE, 8'h00, 4'd2, 16'h002C, 8'h01, 16'h0055, 48'h1234_5678_9ABC, 32'h3B9A_C9FF);
    run_frame(1'b1);
    check_regs("etype");

    // Overflow: two commits without clearing
    wb_write(BASE + 32'h04, 32'd7); m_status = '0;
    build_frame(58, ETYPE, 8'h10, 4'd2, 16'h002C, 8'h00, 16'h0001, 48'h10, 32'h10);
    run_frame(1'b0);
    build_frame(70, ETYPE, 8'h10, 4'd2, 16'h002C, 8'h00, 16'h0002, 48'h11, 32'h11);
    run_frame(1'b0);
    check_regs("ovf");

    // Enable cleared mid-frame only affects the next frame
    build_frame(60, ETYPE, 8'h21, 4'd2, 16'h002C, 8'h02, 16'h00AB, 48'h22, 32'h22);
    fork
      send_frame(1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        wb_write(BASE, 32'd0);
      end
    join
    model_frame(1'b1); m_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    build_frame(58, ETYPE, 8'h30, 4'd2, 16'h002C, 8'h03, 16'h00CD, 48'h33, 32'h33);
    run_frame(1'b1);
    check_regs("disabled");

    // Reset at byte 20 of a frame
    wb_write(BASE, 32'd1); m_en = 1'b1;
    build_frame(60, ETYPE, 8'h10, 4'd2, 16'h002C, 8'h00, 16'h0BAD, 48'h44, 32'h44);
    for (int i = 0; i < 20; i++) begin
      bus_if.axis_tdata_i = frm[i]; bus_if.axis_tvalid_i = 1'b1; bus_if.axis_tlast_i = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.axis_tdata_i = frm[20];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.axis_tvalid_i = 1'b0;
    model_reset();
    check_regs("mid_rst");
    wb_write(BASE, 32'd1); m_en = 1'b1;
    build_frame(58, ETYPE, 8'h10, 4'd2, 16'h002C, 8'h00, 16'h600D, 48'h55, 32'h55);
    run_frame(1'b1);
    check_regs("after_rst");

    // Randomized frames, enable toggles and W1C writes
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = 32'($urandom_range(0, 7));
        wb_write(BASE + 32'h04, w);
        m_status = m_status & ~w[2:0];
      end
      if ($urandom_range(0, 4) == 0) begin
        m_en = ~m_en;
        wb_write(BASE, {31'd0, m_en});
      end
      random_frame();
      run_frame(1'b1);
      check_regs($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ptp_rx_parser.md
PTP_RX_PARSER -- requirements
Module: ptp_rx_parser

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0200, Wishbone register base; decode uses addr[7:0] offsets when addr[31:8] == BASE_ADDR[31:8].
REQ-002 SHALL have parameter ETHERTYPE, default 16'h88F7, accepted PTP EtherType.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 axis_tdata_i  in  8  frame byte, first byte = Ethernet destination MAC[47:40].
REQ-007 axis_tvalid_i  in  1  byte valid.
REQ-008 axis_tready_o  out  1  byte accepted.
REQ-009 axis_tlast_i  in  1  last byte of frame.
REQ-010 wbs_addr_i  in  32  register address.
REQ-011 wbs_data_i  in  32  write data.
REQ-012 wbs_data_o  out  32  read data, valid while wbs_ack_o = 1.
REQ-013 wbs_we_i  in  1  1 = write.
REQ-014 wbs_stb_i  in  1  request strobe.
REQ-015 wbs_ack_o  out  1  single-cycle acknowledge.

Function
REQ-016 SHALL hold axis_tready_o = 1 in every cycle except the reset cycle; a beat is one cycle with tvalid & tready.
REQ-017 SHALL track frame boundaries in every state: the first beat after reset, or after a tlast beat, is byte 0.
REQ-018 SHALL parse a frame only when CTRL.enable = 1 at byte 0; frames that start with enable = 0 are consumed and dropped without side effects.
REQ-019 SHALL implement states IDLE, PARSE, DROP: IDLE->PARSE on byte 0 with enable = 1; IDLE->DROP on byte 0 with enable = 0 and no tlast; PARSE->DROP on EtherType mismatch at byte 13; PARSE->IDLE on tlast; DROP->IDLE on tlast.
REQ-020 SHALL use a 6-bit byte index and capture into shadow registers as follows.
  - bytes 12-13: EtherType.
  - byte 14: transportSpecific[7:4], messageType[3:0].
  - byte 15: versionPTP[3:0].
  - bytes 16-17: messageLength.
  - byte 18: domainNumber.
  - bytes 44-45: sequenceId.
  - bytes 48-53: seconds[47:0].
  - bytes 54-57: nanoseconds.
  - All multi-byte fields are MSB first.
REQ-021 SHALL commit the shadow registers to the visible registers, set STATUS.valid, and increment RX_CNT in the cycle after a tlast beat in PARSE with byte index >= 57; a frame of 58 bytes is the minimum, and longer frames (padding, FCS) are accepted.
REQ-022 SHALL treat tlast in PARSE with byte index < 57 as a runt: no commit, set STATUS.err, increment ERR_CNT one cycle later.
REQ-023 SHALL treat an EtherType mismatch as silently dropped: no error and no counter change.
REQ-024 SHALL set STATUS.ovf if STATUS.valid is already 1 at commit; the new data overwrites the old.
REQ-025 SHALL saturate the byte index at 63 for frames longer than 63 bytes.
REQ-026 SHALL wrap RX_CNT and ERR_CNT from 32'hFFFF_FFFF to 0.
REQ-027 SHALL use the following registers (offsets from BASE_ADDR); unmapped reads return 0 and unmapped writes are ignored, both still acked.
  - 0x00 CTRL: bit0 enable (RW).
  - 0x04 STATUS: bit0 valid, bit1 err, bit2 ovf; each RO and write-1-to-clear.
  - 0x08 HDR: [31:28] transportSpecific, [27:24] messageType, [19:16] versionPTP, [15:0] messageLength.
  - 0x0C ID: [23:16] domainNumber, [15:0] sequenceId.
  - 0x10 SEC_HI: seconds[47:32] in [15:0].
  - 0x14 SEC_LO: seconds[31:0].
  - 0x18 NSEC.
  - 0x1C RX_CNT (RO).
  - 0x20 ERR_CNT (RO).
REQ-028 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after wbs_stb_i = 1 with wbs_ack_o = 0; it SHALL not re-ack until wbs_stb_i has been low for at least one cycle.
REQ-029 SHALL perform a write in the ack cycle.
REQ-030 SHALL register read data so it is valid during the ack cycle; wbs_data_o = 0 otherwise.
REQ-031 SHALL give priority to hardware set over a same-cycle W1C of the same STATUS bit.
REQ-032 SHALL let a CTRL.enable change mid-frame affect only subsequent frames.

Reset
REQ-033 SHALL, on rst = 1 at a rising edge, clear the following and return to IDLE with byte index 0.
  - Outputs: axis_tready_o, wbs_ack_o, wbs_data_o.
  - Registers: all shadow and visible registers, CTRL, STATUS, RX_CNT, ERR_CNT.
REQ-034 SHALL abandon any frame in progress on reset without commit or error; the first beat after reset is byte 0.

Verification
REQ-035 Write CTRL = 1, send 58-byte Sync: EtherType 88F7, byte14 = 8'h10, versionPTP 2, length 16'h002C, domain 0, seqId 16'h1234, seconds 48'h0000_0000_0016, ns 32'h0000_AAAA, tlast on byte 57 -> STATUS = 1, HDR = 32'h1002_002C, ID = 32'h0000_1234, SEC_LO = 32'h16, NSEC = 32'hAAAA, RX_CNT = 1.
REQ-036 Send 40-byte frame with tlast on byte 39 -> STATUS.err = 1, ERR_CNT = 1, HDR unchanged; then write STATUS = 2 -> STATUS.err = 0.
REQ-037 Send frame with EtherType 0800 followed by a valid PTP frame -> only the second commits, RX_CNT = 1, ERR_CNT = 0.
REQ-038 Two valid frames (seqId 1 then 2) without clearing STATUS -> STATUS = 5 (valid + ovf), ID[15:0] = 2.
REQ-039 CTRL = 0, send valid frame -> STATUS = 0, RX_CNT = 0, tready = 1 throughout; assert rst at byte 20 of a later frame -> all registers 0, next frame parsed correctly after re-enable.
REQ-040 Wishbone protocol: stb held 3 cycles -> exactly one ack pulse; read of offset 0x40 -> data 0 with ack.
